// File: rtl/affine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : affine_pkg
//  Description : Shared constants and FSM state type for the affine
//                encoder/decoder family (Y = SCALE*X + OFFSET).
//  Revision    : 1.0  initial release
// ============================================================================
package affine_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int OFFSET_DEF = 17;
    localparam int SCALE_DEF  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } affine_state_e;

endpackage
`default_nettype wire

// File: rtl/affine_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : affine_decoder_if
//  Description : Input/output valid-ready handshake bundle of the affine
//                decoder. The master side produces Y and consumes X/exact.
//  Revision    : 1.0  initial release
// ============================================================================
interface affine_decoder_if
    import affine_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] Y;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] X;
    logic                    exact;

    modport master (
        output in_valid, Y, out_ready,
        input  in_ready, out_valid, X, exact
    );

    modport slave (
        input  in_valid, Y, out_ready,
        output in_ready, out_valid, X, exact
    );

endinterface
`default_nettype wire

// File: rtl/udiv_restoring.sv
`default_nettype none
// ============================================================================
//  Module      : udiv_restoring
//  Description : Unsigned N-bit iterative restoring divider. One
//                shift-subtract step per cycle, N steps per division.
//                done_o pulses for one cycle once quotient/remainder are final.
//  Revision    : 1.0  initial release
// ============================================================================
module udiv_restoring #(
    parameter int N = 17
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         start_i,
    input  wire logic [N-1:0] dividend_i,
    input  wire logic [N-1:0] divisor_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [N-1:0]      quotient_o,
    output logic [N-1:0]      remainder_o
);

    localparam int            CW     = $clog2(N + 1);
    localparam logic [CW-1:0] c_last = CW'(N - 1);

    logic [N-1:0]  quo_q;
    logic [N-1:0]  rem_q;
    logic [N-1:0]  dvs_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;

    logic [N:0]    w_partial;
    logic [N:0]    w_trial;
    logic          w_fits;
    logic [N-1:0]  w_rem_next;
    logic          w_unused;

    // Trial subtraction of the divisor from the shifted partial remainder.
    // The remainder stays below the divisor, so the top bit of w_trial is
    // always zero whenever the subtraction result is kept.
    always_comb begin
        w_partial  = {rem_q, quo_q[N-1]};
        w_trial    = w_partial - {1'b0, dvs_q};
        w_fits     = (w_partial >= {1'b0, dvs_q});
        w_rem_next = w_fits ? w_trial[N-1:0] : w_partial[N-1:0];
    end

    assign w_unused = w_trial[N];

    // Load operands on start, then iterate N times; done pulses after the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                quo_q  <= dividend_i;
                rem_q  <= '0;
                dvs_q  <= divisor_i;
                cnt_q  <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                quo_q <= {quo_q[N-2:0], w_fits};
                rem_q <= w_rem_next;
                if (cnt_q == c_last) begin
                    cnt_q  <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule
`default_nettype wire

// File: rtl/affine_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : affine_decoder
//  Description : Inverts Y = SCALE*X + OFFSET. Forms d = Y - OFFSET at
//                WIDTH+1 bits, divides |d| by SCALE with an iterative
//                restoring divider, reapplies the sign (truncation toward
//                zero) and flags whether the division was exact.
//                One result in flight; valid/ready on both sides.
//  Revision    : 1.0  initial release
// ============================================================================
module affine_decoder
    import affine_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int OFFSET = OFFSET_DEF,
    parameter int SCALE  = SCALE_DEF
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    affine_decoder_if.slave bus
);

    // One extra bit so that Y - OFFSET can never overflow.
    localparam int                   N        = WIDTH + 1;
    localparam logic signed [N-1:0]  c_offset = N'(OFFSET);
    localparam logic        [N-1:0]  c_scale  = N'(SCALE);

    affine_state_e state_q, state_d;

    logic                    sign_q;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic                    exact_q, exact_d;

    logic                    w_start;
    logic                    w_in_ready;
    logic                    w_out_valid;
    logic signed [N-1:0]     w_d;
    logic        [N-1:0]     w_mag;
    logic                    w_div_busy;
    logic                    w_div_done;
    logic        [N-1:0]     w_quo;
    logic        [N-1:0]     w_rem;
    logic        [N-1:0]     w_q_signed;
    logic                    w_unused;

    // Offset removal and magnitude split of the accepted sample.
    always_comb begin
        w_d   = $signed({bus.Y[WIDTH-1], bus.Y}) - c_offset;
        w_mag = w_d[N-1] ? -w_d : w_d;
    end

    udiv_restoring #(
        .N (N)
    ) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (w_start),
        .dividend_i  (w_mag),
        .divisor_i   (c_scale),
        .busy_o      (w_div_busy),
        .done_o      (w_div_done),
        .quotient_o  (w_quo),
        .remainder_o (w_rem)
    );

    // Reapply the sign to the magnitude quotient; only WIDTH bits are kept.
    assign w_q_signed = sign_q ? -w_quo : w_quo;
    assign w_unused   = w_q_signed[N-1] ^ w_div_busy;

    // Next-state, handshake outputs and result capture.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        exact_d     = exact_q;
        w_start     = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_start = 1'b1;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (w_div_done) begin
                    x_d     = w_q_signed[WIDTH-1:0];
                    exact_d = (w_rem == '0);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, sign and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            x_q     <= '0;
            exact_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            exact_q <= exact_d;
            if (w_start) begin
                sign_q <= w_d[N-1];
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.X         = x_q;
    assign bus.exact     = exact_q;

endmodule
`default_nettype wire

// File: tb/tb_affine_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_affine_decoder
//  Description : Self-checking bench for affine_decoder: directed decode
//                cases, backpressure, reset abort, random-Y decode against
//                an arithmetic model and an encode/decode round trip.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_affine_decoder;

    localparam int WIDTH   = 16;
    localparam int OFFSET  = 17;
    localparam int SCALE   = 6;
    localparam int LATENCY = WIDTH + 2;

    logic clk;
    logic rst_n;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    affine_decoder_if #(.WIDTH(WIDTH)) bus ();

    affine_decoder #(
        .WIDTH  (WIDTH),
        .OFFSET (OFFSET),
        .SCALE  (SCALE)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, SV division truncates toward zero.
    function automatic void model(input logic signed [15:0] y,
                                  output logic signed [15:0] x, output logic e);
        int d;
        d = int'(y) - OFFSET;
        x = 16'(d / SCALE);
        e = ((d % SCALE) == 0);
    endfunction

    // One full transaction: optional idle gap, accept, latency check, result
    // check, optional backpressure with ignored in_valid pulses, drain.
    task automatic run_one(input string tag, input logic signed [15:0] y,
                           input logic signed [15:0] ex_x, input logic ex_e,
                           input int idle, input int hold, input bit noise);
        int cyc;
        repeat (idle) begin
            @(posedge clk); #1;
        end
        check({tag, ":in_ready"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.Y        = y;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.Y        = 16'($urandom);
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            if (noise) begin
                bus.in_valid = 1'($urandom);
                bus.Y        = 16'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check({tag, ":latency"}, cyc, LATENCY);
        check({tag, ":X"}, bus.X, ex_x);
        check({tag, ":exact"}, bus.exact, ex_e);
        repeat (hold) begin
            bus.in_valid = 1'($urandom);
            bus.Y        = 16'($urandom);
            @(posedge clk); #1;
            check({tag, ":hold_valid"}, bus.out_valid, 1);
            check({tag, ":hold_X"}, bus.X, ex_x);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, ":drained"}, bus.out_valid, 0);
        check({tag, ":X_kept"}, bus.X, ex_x);
    endtask

    initial begin
        logic signed [15:0] y;
        logic signed [15:0] mx;
        logic               me;
        int                 xv;
        int                 seen;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.Y         = '0;

        // Reset state
        #1;
        check("rst:out_valid", bus.out_valid, 0);
        check("rst:X", bus.X, 0);
        check("rst:exact", bus.exact, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst:in_ready", bus.in_ready, 1);

        // Directed decodes; the first one is accepted on the first edge after reset
        run_one("y17",    16'sd17,     16'sd0,     1'b1, 0, 0,  1'b0);
        run_one("y23",    16'sd23,     16'sd1,     1'b1, 0, 0,  1'b0);
        run_one("ym1",    -16'sd1,     -16'sd3,    1'b1, 1, 0,  1'b1);
        run_one("y20",    16'sd20,     16'sd0,     1'b0, 0, 0,  1'b1);
        run_one("ymax",   16'sd32767,  16'sd5458,  1'b0, 0, 0,  1'b0);
        run_one("ymin",   -16'sd32768, -16'sd5464, 1'b0, 0, 0,  1'b0);
        // Backpressure: ten cycles of out_ready=0 with in_valid pulses
        run_one("bp",     16'sd41,     16'sd4,     1'b1, 0, 10, 1'b1);
        run_one("bp_next",16'sd11,     -16'sd1,    1'b1, 0, 0,  1'b0);

        // Reset in the middle of the division discards the operation
        bus.in_valid = 1'b1;
        bus.Y        = 16'sd100;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort:out_valid", bus.out_valid, 0);
        check("abort:X", bus.X, 0);
        check("abort:exact", bus.exact, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("abort:no_result", seen, 0);
        run_one("y29", 16'sd29, 16'sd2, 1'b1, 0, 0, 1'b0);

        // Arbitrary Y (including wrapped encodings) against the model
        for (int i = 0; i < 300; i++) begin
            y = 16'($urandom);
            model(y, mx, me);
            run_one("rand_y", y, mx, me, int'($urandom_range(2, 0)),
                    int'($urandom_range(3, 0)), 1'b1);
        end

        // Encode/decode round trip over the non-wrapping range
        for (int i = 0; i < 1500; i++) begin
            xv = int'($urandom_range(10922, 0)) - 5464;
            y  = 16'(SCALE * xv + OFFSET);
            run_one("roundtrip", y, 16'(xv), 1'b1, int'($urandom_range(2, 0)),
                    int'($urandom_range(3, 0)), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
